// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, req/ack responder, one quotient bit per clock
// Define SEQ_DIVIDER_RADIX4_EN to retire two quotient bits per clock (bitwidth must then be even).
module seq_divider #(
    parameter int bitwidth = 26
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic [bitwidth-1:0] dividend_i,
    input  logic [bitwidth-1:0] divisor_i,
    output logic                ack_o,
    output logic                busy_o,
    output logic [bitwidth-1:0] quotient_o,
    output logic [bitwidth-1:0] remainder_o,
    output logic                div_by_zero_o
);
`ifdef SEQ_DIVIDER_RADIX4_EN
    localparam int STEPS = bitwidth / 2;
`else
    localparam int STEPS = bitwidth;
`endif
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [bitwidth:0]   rem_q, rem_d;
    logic [bitwidth-1:0] quo_q, quo_d;
    logic [bitwidth-1:0] dvs_q, dvs_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [bitwidth-1:0] quot_out_q, quot_out_d;
    logic [bitwidth-1:0] rem_out_q, rem_out_d;
    logic                dbz_q, dbz_d;
    logic [2*bitwidth:0] step1;
`ifdef SEQ_DIVIDER_RADIX4_EN
    logic [2*bitwidth:0] step2;
`endif

    // quo holds the not-yet-consumed dividend bits on the left and the quotient bits on the right
    function automatic logic [2*bitwidth:0] div_step(
        input logic [bitwidth:0]   rem,
        input logic [bitwidth-1:0] quo,
        input logic [bitwidth-1:0] dvs
    );
        logic [bitwidth+1:0] sh;
        logic [bitwidth+1:0] diff;
        logic                ge;
        sh   = {rem, quo[bitwidth-1]};
        diff = sh - {2'b00, dvs};
        ge   = (sh >= {2'b00, dvs});
        return {(ge ? diff[bitwidth:0] : sh[bitwidth:0]), quo[bitwidth-2:0], ge};
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            zero_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dbz_q      <= dbz_d;
        end
    end

    // A new request wins in every state, so an operation in flight is silently dropped.
    always_comb begin
        state_d = state_q;
        if (req_i) begin
            state_d = (divisor_i == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN:     if (cnt_q == CW'(1)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        step1  = div_step(rem_q, quo_q, dvs_q);
`ifdef SEQ_DIVIDER_RADIX4_EN
        step2  = div_step(step1[2*bitwidth:bitwidth], step1[bitwidth-1:0], dvs_q);
`endif
        if (req_i) begin
            dvs_d  = divisor_i;
            zero_d = (divisor_i == '0);
            cnt_d  = CW'(STEPS);
            if (divisor_i == '0) begin
                rem_d = {1'b0, dividend_i};
                quo_d = '1;
            end else begin
                rem_d = '0;
                quo_d = dividend_i;
            end
        end else if (state_q == RUN) begin
`ifdef SEQ_DIVIDER_RADIX4_EN
            {rem_d, quo_d} = step2;
`else
            {rem_d, quo_d} = step1;
`endif
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        ack_d      = 1'b0;
        busy_d     = busy_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dbz_d      = dbz_q;
        if (req_i) begin
            busy_d = (divisor_i != '0);
        end else if (state_q == DONE) begin
            ack_d      = 1'b1;
            busy_d     = 1'b0;
            quot_out_d = quo_q;
            rem_out_d  = rem_q[bitwidth-1:0];
            dbz_d      = zero_q;
        end
    end

    assign ack_o         = ack_q;
    assign busy_o        = busy_q;
    assign quotient_o    = quot_out_q;
    assign remainder_o   = rem_out_q;
    assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;
    localparam int W = 26;
`ifdef SEQ_DIVIDER_RADIX4_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ack_o, busy_o, dbz_o;
    logic [W-1:0] quotient_o, remainder_o;

    always #5 clk = ~clk;

    seq_divider #(.bitwidth(W)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req),
        .dividend_i(dividend), .divisor_i(divisor),
        .ack_o(ack_o), .busy_o(busy_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o),
        .div_by_zero_o(dbz_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accepted request completes a fixed number of edges later unless superseded.
    int           cyc = 0;
    bit           started = 0;
    bit           pend = 0;
    int           pcnt = 0;
    logic [W-1:0] pq = '0, pr = '0;
    logic         pz = 1'b0;
    logic         m_ack = 1'b0, m_busy = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        m_ack = 1'b0;
        if (reset) begin
            pend = 0; m_busy = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (req) begin
            pend = 1;
            if (divisor == '0) begin
                pq = {W{1'b1}}; pr = dividend; pz = 1'b1; pcnt = 0; m_busy = 1'b0;
            end else begin
                pq = dividend / divisor; pr = dividend % divisor; pz = 1'b0;
                pcnt = STEPS; m_busy = 1'b1;
            end
        end else if (pend) begin
            if (pcnt == 0) begin
                m_ack = 1'b1; m_q = pq; m_r = pr; m_dbz = pz; m_busy = 1'b0; pend = 0;
            end else begin
                pcnt--;
            end
        end
    end

    int           n_ack = 0;
    int           last_ack_edge = 0;
    logic [W-1:0] a_q, a_r;
    logic         a_z;

    always @(negedge clk) begin
        if (started) begin
            chk("ack", {31'd0, ack_o}, {31'd0, m_ack});
            chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
            chk("quotient", {6'd0, quotient_o}, {6'd0, m_q});
            chk("remainder", {6'd0, remainder_o}, {6'd0, m_r});
            chk("div_by_zero", {31'd0, dbz_o}, {31'd0, m_dbz});
            if (ack_o === 1'b1) begin
                n_ack++;
                last_ack_edge = cyc;
                a_q = quotient_o; a_r = remainder_o; a_z = dbz_o;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int k);
        @(negedge clk);
        dividend = a; divisor = b; req = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ack(input int maxc, output bit ok);
        int start;
        start = n_ack;
        ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_ack != start) ok = 1;
        end
    endtask

    task automatic expect_result(input string nm, input int k, input int lat,
                                 input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        bit ok;
        wait_ack(lat + 5, ok);
        chk({nm, "_ack_seen"}, {31'd0, ok}, 32'd1);
        chk({nm, "_ack_edge"}, last_ack_edge, k + lat);
        chk({nm, "_q"}, {6'd0, a_q}, {6'd0, q});
        chk({nm, "_r"}, {6'd0, a_r}, {6'd0, r});
        chk({nm, "_dbz"}, {31'd0, a_z}, {31'd0, z});
    endtask

    initial begin
        int k, k0, n0;
        repeat (3) @(negedge clk);
        chk("reset_q", {6'd0, quotient_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        reset = 1'b0;

        issue(26'(640 << 16), 26'd320, k);
        expect_result("s1", k, STEPS + 1, 26'd131072, 26'd0, 1'b0);

        issue(26'd1000, 26'd7, k);
        expect_result("s2a", k, STEPS + 1, 26'd142, 26'd6, 1'b0);
        issue(26'd5, 26'd9, k);
        expect_result("s2b", k, STEPS + 1, 26'd0, 26'd5, 1'b0);
        issue(26'd0, 26'd5, k);
        expect_result("s2c", k, STEPS + 1, 26'd0, 26'd0, 1'b0);

        issue(26'd123, 26'd0, k);
        expect_result("s3a", k, 1, 26'h3FFFFFF, 26'd123, 1'b1);
        issue(26'd1000, 26'd7, k);
        expect_result("s3b", k, STEPS + 1, 26'd142, 26'd6, 1'b0);

        n0 = n_ack;
        issue(26'd100, 26'd3, k0);
        repeat (8) @(negedge clk);
        issue(26'd200, 26'd10, k);
        chk("s4_restart_edge", k, k0 + 10);
        expect_result("s4", k, STEPS + 1, 26'd20, 26'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("s4_single_ack", n_ack - n0, 32'd1);

        issue(26'd1000, 26'd7, k0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("s5_edge", cyc, k0 + 12);
        chk("s5_q", {6'd0, quotient_o}, 32'd0);
        chk("s5_r", {6'd0, remainder_o}, 32'd0);
        chk("s5_busy", {31'd0, busy_o}, 32'd0);
        n0 = n_ack;
        repeat (STEPS + 6) @(negedge clk);
        chk("s5_no_ack", n_ack - n0, 32'd0);
        issue(26'h3FFFFFF, 26'd1, k);
        expect_result("s5b", k, STEPS + 1, 26'h3FFFFFF, 26'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
